// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP               = 32'hE1A0_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          BUF_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetched {pc, instr} words sitting between memory and IF/ID.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_entry_t  entries [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (!do_push && do_pop)
        count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !clear)
      entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: issues word requests, tracks in-flight responses,
// drops stale words after a redirect and feeds the IF/ID register from a FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_f;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_count;
  logic [CW:0]   occupancy;
  logic          accept;
  logic          stale;
  logic          push;
  logic          pop;
  logic          buf_full;
  logic          buf_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign occupancy  = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req   = reset && !stall_f && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_addr  = pc_f;
  assign pc_out     = pc_f;
  assign accept     = imem_req && imem_ack;
  assign stale      = redirect_valid || (drop_cnt != '0);
  assign push       = imem_rvalid && !stale;
  assign pop        = !redirect_valid && !stall_d && !buf_empty;
  assign push_entry = '{pc: resp_pc, instr: imem_rdata};

  fetch_buffer #(.DEPTH(BUF_DEPTH), .CW(CW)) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redirect_valid),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // resp_pc is the address the next non-stale response belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        pc_f    <= redirect_pc & ~32'd3;
        resp_pc <= redirect_pc & ~32'd3;
      end else begin
        if (accept)
          pc_f <= pc_f + 32'd4;
        if (push)
          resp_pc <= resp_pc + 32'd4;
      end

      if (accept && !imem_rvalid)
        outstanding <= outstanding + CW'(1);
      else if (!accept && imem_rvalid)
        outstanding <= outstanding - CW'(1);

      if (redirect_valid)
        drop_cnt <= outstanding - CW'(imem_rvalid);
      else if (imem_rvalid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
      pc_d    <= '0;
    end else if (redirect_valid || flush_d) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
    end else if (!stall_d) begin
      if (!buf_empty) begin
        valid_d <= 1'b1;
        instr_d <= head.instr;
        pc_d    <= head.pc;
      end else begin
        valid_d <= 1'b0;
        instr_d <= NOP;
      end
    end
  end

  // Request throttling keeps the buffer from ever overflowing.
  assert property (@(posedge clk) disable iff (!reset) !(imem_rvalid && buf_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model and memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = BUF_DEPTH_DEFAULT;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_out;
  logic        valid_d;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC_DEFAULT), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .pc_out         (pc_out)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  // Reference model: fetch PC, in-flight/drop counts, buffer queue, IF/ID slot.
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid;
  int          m_out, m_drop;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
    end
  endtask

  task automatic reset_model();
    m_pc    = RESET_PC_DEFAULT;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pcd   = 32'd0;
    m_out   = 0;
    m_drop  = 0;
    q_pc.delete();
    q_instr.delete();
    mem_addr.delete();
    mem_due.delete();
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_req"},     32'(imem_req), 32'd0);
    checkOutput({tag, "_valid_d"}, 32'(valid_d),  32'd0);
    checkOutput({tag, "_instr_d"}, instr_d,       NOP);
    checkOutput({tag, "_pc_d"},    pc_d,          32'd0);
    checkOutput({tag, "_pc_out"},  pc_out,        RESET_PC_DEFAULT);
  endtask

  // Called just after a rising edge; leaves the DUT held in reset for one edge.
  task automatic reset_dut();
    reset = 1'b0;
    {stall_f, stall_d, flush_d, redirect_valid, imem_ack, imem_rvalid} = '0;
    redirect_pc = 32'd0;
    imem_rdata  = 32'd0;
    reset_model();
    @(posedge clk);
    #1 check_reset_state("rst");
    #1 reset = 1'b1;
  endtask

  // Asserts reset in the middle of a cycle and checks outputs before any edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    imem_rvalid = 1'b0;
    #1 check_reset_state("mid");
    reset_model();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic applyStimulus(input logic sf, input logic sd, input logic fl, input logic rd,
                               input logic [31:0] rpc, input logic ack);
    logic        rv, exp_req, acc;
    logic [31:0] rdat, req_addr, rsp_addr;
    int          old_size;
    @(negedge clk);
    stall_f = sf; stall_d = sd; flush_d = fl; redirect_valid = rd;
    redirect_pc = rpc; imem_ack = ack;
    rv       = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    rsp_addr = rv ? mem_addr[0] : 32'd0;
    rdat     = rv ? mem_word(rsp_addr) : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
    exp_req  = !sf && !rd && ((m_out + q_pc.size()) < DEPTH);
    req_addr = m_pc;
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", imem_addr, req_addr);
    @(posedge clk);
    acc = exp_req && ack;

    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (acc) begin
      mem_addr.push_back(req_addr);
      mem_due.push_back(cyc + $urandom_range(lat_max, lat_min));
    end

    old_size = q_pc.size();
    if (rd) begin
      m_drop  = m_out - int'(rv);
      q_pc.delete();
      q_instr.delete();
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc    = rpc & 32'hFFFF_FFFC;
    end else begin
      if (fl) begin
        m_valid = 1'b0;
        m_instr = NOP;
        if (!sd && old_size > 0) begin
          void'(q_pc.pop_front());
          void'(q_instr.pop_front());
        end
      end else if (!sd) begin
        if (old_size > 0) begin
          m_valid = 1'b1;
          m_pcd   = q_pc.pop_front();
          m_instr = q_instr.pop_front();
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          q_pc.push_back(rsp_addr);
          q_instr.push_back(rdat);
        end
      end
      if (acc) m_pc = m_pc + 32'd4;
    end
    m_out = m_out + int'(acc) - int'(rv);
    cyc++;

    #1;
    checkOutput("valid_d", 32'(valid_d), 32'(m_valid));
    checkOutput("instr_d", instr_d, m_instr);
    checkOutput("pc_d",    pc_d,    m_pcd);
    checkOutput("pc_out",  pc_out,  m_pc);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    {stall_f, stall_d, flush_d, redirect_valid, imem_ack, imem_rvalid} = '0;
    redirect_pc = 32'd0;
    imem_rdata  = 32'd0;
    reset_model();
    repeat (2) @(posedge clk);
    #1 check_reset_state("por");
    #1 reset = 1'b1;

    // Streaming with a single-cycle memory
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("stream_valid", 32'(valid_d), 32'd1);
    checkOutput("stream_pc_d",  pc_d,         32'd0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Memory backpressure, then decode stall
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect with two requests in flight
    reset_dut();
    lat_min = 3; lat_max = 3;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      n++;
    end
    checkOutput("redir_valid", 32'(valid_d), 32'd1);
    checkOutput("redir_pc_d",  pc_d,         32'h100);

    // Flush and redirect together, unaligned target
    lat_min = 1; lat_max = 1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h43, 1'b1);
    checkOutput("simul_pc_out",  pc_out,       32'h40);
    checkOutput("simul_valid_d", 32'(valid_d), 32'd0);
    checkOutput("simul_instr_d", instr_d,      NOP);

    // Address wrap at the top of memory
    reset_dut();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap_redirect", pc_out, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("wrap_pc", pc_out, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    mid_reset();

    // Randomized traffic with variable latency and occasional resets
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) mid_reset();
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
